alu_result_stage: RTL and testbench

- Registered stage directly downstream of the ALU.
- Captures the ALU result, status and writeback metadata into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Holds the architectural status-flag register, updated only when an entry commits.
- Gives decode a combinational forwarding lookup over in-flight results.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/rs_skid_buf.sv | 69 ++++++
 rtl/alu_result_stage.sv | 105 ++++++++++
 tb/tb_alu_result_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath types plus the result-stage entry record.
// The result stage honours the optional ALU_OVF_TRAP_EN build macro.
package alu_pkg;

  typedef logic [15:0] word_16;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } status_t;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    XOR  = 3'd4,
    SLL  = 3'd5,
    SRL  = 3'd6,
    PASS = 3'd7
  } control_e;

  localparam int RS_DEST_W = 4;
  localparam logic [RS_DEST_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    word_16                 result;
    status_t                stat;
    control_e               op;
    logic [RS_DEST_W-1:0]   dest;
    logic                   wr_en;
    logic                   flag_wr;
  } rs_entry_t;

  // Signed add/sub that overflowed must not reach the register file.
  function automatic logic is_ovf_trap(rs_entry_t e);
    return ((e.op == ADD) || (e.op == SUB)) && e.stat.overflow;
  endfunction

endpackage

// File: rtl/rs_skid_buf.sv
// Two-entry valid/ready skid buffer of rs_entry_t; in_ready is registered
// from next-state occupancy so there is no path from out_ready to in_ready.
module rs_skid_buf
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      in_valid,
  output logic      in_ready,
  input  rs_entry_t in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output rs_entry_t out_data,
  output logic      skid_valid,
  output rs_entry_t skid_data
);

  logic [1:0] count;
  logic [1:0] count_nxt;
  rs_entry_t  head_q;
  rs_entry_t  skid_q;
  logic       push;
  logic       pop;

  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_valid  = (count != 2'd0);
  assign skid_valid = (count == 2'd2);
  assign out_data   = head_q;
  assign skid_data  = skid_q;

  always_comb begin
    count_nxt = count;
    case (count)
      2'd0:    if (push) count_nxt = 2'd1;
      2'd1:    if (push && !pop) count_nxt = 2'd2;
               else if (!push && pop) count_nxt = 2'd0;
      2'd2:    if (pop) count_nxt = 2'd1;
      default: count_nxt = 2'd0;
    endcase
    if (flush) count_nxt = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      head_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
      if (flush) begin
        head_q <= '0;
        skid_q <= '0;
      end else begin
        case (count)
          2'd0:    if (push) head_q <= in_data;
          2'd1:    if (push && pop) head_q <= in_data;
                   else if (push) skid_q <= in_data;
          2'd2:    if (pop) head_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: skid-buffered writeback, flag register and forwarding.
// ALU_OVF_TRAP_EN adds ovf_trap and suppresses writeback of overflowed ADD/SUB.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEST_W = RS_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  word_16            in_result,
  input  status_t           in_stat,
  input  control_e          in_op,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_wr_en,
  input  logic              in_flag_wr,
  output logic              out_valid,
  input  logic              out_ready,
  output word_16            out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_wr_en,
  output status_t           flags,
  input  logic [DEST_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output word_16            fwd_data
`ifdef ALU_OVF_TRAP_EN
  ,
  output logic              ovf_trap
`endif
);

  rs_entry_t in_entry;
  rs_entry_t head;
  rs_entry_t skid;
  logic      skid_valid;
  logic      pop;
  logic      hit_head;
  logic      hit_skid;
  logic      unused_fields;

  function automatic logic wr_qual(rs_entry_t e);
`ifdef ALU_OVF_TRAP_EN
    return e.wr_en && (e.dest != REG_ZERO) && !is_ovf_trap(e);
`else
    return e.wr_en && (e.dest != REG_ZERO);
`endif
  endfunction

  always_comb begin
    in_entry         = '0;
    in_entry.result  = in_result;
    in_entry.stat    = in_stat;
    in_entry.op      = in_op;
    in_entry.dest    = in_dest;
    in_entry.wr_en   = in_wr_en;
    in_entry.flag_wr = in_flag_wr;
  end

  rs_skid_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_entry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (head),
    .skid_valid (skid_valid),
    .skid_data  (skid)
  );

  assign pop        = out_valid && out_ready;
  assign out_result = head.result;
  assign out_dest   = head.dest;
  assign out_wr_en  = wr_qual(head);

  // Younger (skid) entry overrides the head when both target fwd_addr.
  always_comb begin
    hit_head = out_valid  && wr_qual(head) && (head.dest == fwd_addr);
    hit_skid = skid_valid && wr_qual(skid) && (skid.dest == fwd_addr);
    fwd_hit  = hit_head || hit_skid;
    fwd_data = '0;
    if (hit_skid)      fwd_data = skid.result;
    else if (hit_head) fwd_data = head.result;
  end

  // A pop that coincides with flush was already accepted downstream.
  always_ff @(posedge clk) begin
    if (rst)                       flags <= '0;
    else if (pop && head.flag_wr)  flags <= head.stat;
  end

`ifdef ALU_OVF_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst || flush) ovf_trap <= 1'b0;
    else              ovf_trap <= pop && is_ovf_trap(head);
  end
`endif

  assign unused_fields = ^{head.op, skid.stat, skid.op, skid.flag_wr};

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (default or ALU_OVF_TRAP_EN build).
module tb_alu_result_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, in_wr_en, in_flag_wr;
  word_16     in_result;
  status_t    in_stat;
  control_e   in_op;
  logic [3:0] in_dest;
  logic       out_valid, out_ready, out_wr_en;
  word_16     out_result;
  logic [3:0] out_dest;
  status_t    flags;
  logic [3:0] fwd_addr;
  logic       fwd_hit;
  word_16     fwd_data;
`ifdef ALU_OVF_TRAP_EN
  logic       ovf_trap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.DEST_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_stat(in_stat), .in_op(in_op), .in_dest(in_dest),
    .in_wr_en(in_wr_en), .in_flag_wr(in_flag_wr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_wr_en(out_wr_en), .flags(flags),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`ifdef ALU_OVF_TRAP_EN
    , .ovf_trap(ovf_trap)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] r, input logic [3:0] st, input control_e op,
                       input logic [3:0] d, input logic wr, input logic fw);
    in_valid   = 1'b1;
    in_result  = r;
    in_stat    = st;
    in_op      = op;
    in_dest    = d;
    in_wr_en   = wr;
    in_flag_wr = fw;
  endtask

  task automatic fwd(input logic [3:0] a);
    fwd_addr = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_stat = '0;
    in_op = PASS; in_dest = '0; in_wr_en = 1'b0; in_flag_wr = 1'b0;
    out_ready = 1'b0; fwd_addr = 4'd3;
    tick(); tick();
    rst = 1'b0;
    fwd(4'd3);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_fwd_hit", 16'(fwd_hit), 16'd0);
    chk("rst_flags", 16'(flags), 16'd0);
    chk("rst_out_result", out_result, 16'h0000);
    chk("rst_out_dest", 16'(out_dest), 16'd0);
    chk("rst_out_wr_en", 16'(out_wr_en), 16'd0);

    // Single push, consumer ready
    out_ready = 1'b1;
    drive(16'h1234, 4'b0000, PASS, 4'd3, 1'b1, 1'b0);
    tick(); in_valid = 1'b0;
    chk("p1_out_valid", 16'(out_valid), 16'd1);
    chk("p1_out_result", out_result, 16'h1234);
    chk("p1_out_dest", 16'(out_dest), 16'd3);
    chk("p1_out_wr_en", 16'(out_wr_en), 16'd1);
    fwd(4'd3);
    chk("p1_fwd_hit", 16'(fwd_hit), 16'd1);
    chk("p1_fwd_data", fwd_data, 16'h1234);
    fwd(4'd7);
    chk("p1_fwd_miss_data", fwd_data, 16'h0000);
    tick();
    chk("p1_drained", 16'(out_valid), 16'd0);
    chk("p1_in_ready", 16'(in_ready), 16'd1);

    // Fill both entries, forwarding prefers the younger one, ordered drain
    out_ready = 1'b0;
    drive(16'h0001, 4'b0000, PASS, 4'd2, 1'b1, 1'b0);
    tick();
    chk("fill_in_ready_1", 16'(in_ready), 16'd1);
    drive(16'h0002, 4'b0000, PASS, 4'd2, 1'b1, 1'b0);
    tick(); in_valid = 1'b0;
    chk("fill_in_ready_2", 16'(in_ready), 16'd0);
    chk("fill_head", out_result, 16'h0001);
    fwd(4'd2);
    chk("fill_fwd_hit", 16'(fwd_hit), 16'd1);
    chk("fill_fwd_young", fwd_data, 16'h0002);
    tick();
    chk("hold_result", out_result, 16'h0001);
    chk("hold_dest", 16'(out_dest), 16'd2);
    chk("hold_valid", 16'(out_valid), 16'd1);
    out_ready = 1'b1;
    tick();
    chk("drain_b", out_result, 16'h0002);
    chk("drain_b_valid", 16'(out_valid), 16'd1);
    chk("drain_in_ready", 16'(in_ready), 16'd1);
    tick();
    chk("drain_empty", 16'(out_valid), 16'd0);
    fwd(4'd2);
    chk("drain_fwd_hit", 16'(fwd_hit), 16'd0);

    // Back-to-back throughput
    drive(16'h0101, 4'b0000, PASS, 4'd6, 1'b1, 1'b0);
    tick();
    chk("tp_v1", out_result, 16'h0101);
    drive(16'h0202, 4'b0000, PASS, 4'd6, 1'b1, 1'b0);
    tick();
    chk("tp_v2", out_result, 16'h0202);
    chk("tp_in_ready", 16'(in_ready), 16'd1);
    drive(16'h0303, 4'b0000, PASS, 4'd6, 1'b1, 1'b0);
    tick(); in_valid = 1'b0;
    chk("tp_v3", out_result, 16'h0303);
    chk("tp_v3_valid", 16'(out_valid), 16'd1);
    tick();
    chk("tp_empty", 16'(out_valid), 16'd0);

    // r0 destination is never written or forwarded
    out_ready = 1'b0;
    drive(16'h00aa, 4'b0000, PASS, 4'd0, 1'b1, 1'b0);
    tick(); in_valid = 1'b0;
    chk("r0_out_valid", 16'(out_valid), 16'd1);
    chk("r0_out_wr_en", 16'(out_wr_en), 16'd0);
    fwd(4'd0);
    chk("r0_fwd_hit", 16'(fwd_hit), 16'd0);
    chk("r0_fwd_data", fwd_data, 16'h0000);
    out_ready = 1'b1;
    tick();
    chk("r0_drained", 16'(out_valid), 16'd0);

    // Flags update only on pop of a flag-writing entry
    out_ready = 1'b0;
    drive(16'h0000, 4'b1000, SUB, 4'd1, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    chk("flag_pre_pop_1", 16'(flags), 16'h0000);
    tick();
    chk("flag_pre_pop_2", 16'(flags), 16'h0000);
    out_ready = 1'b1;
    tick();
    chk("flag_zero", 16'(flags), 16'h0008);
    drive(16'h8000, 4'b0100, SUB, 4'd1, 1'b1, 1'b0);
    tick(); in_valid = 1'b0;
    tick();
    chk("flag_no_wr", 16'(flags), 16'h0008);
    chk("flag_no_wr_empty", 16'(out_valid), 16'd0);

    // Flush with a full buffer and a pending push
    out_ready = 1'b0;
    drive(16'h0010, 4'b0000, PASS, 4'd4, 1'b1, 1'b1);
    tick();
    drive(16'h0020, 4'b0000, PASS, 4'd4, 1'b1, 1'b1);
    tick();
    chk("fl_full", 16'(in_ready), 16'd0);
    drive(16'h0030, 4'b0000, PASS, 4'd4, 1'b1, 1'b1);
    flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 16'(out_valid), 16'd0);
    chk("fl_in_ready", 16'(in_ready), 16'd1);
    fwd(4'd4);
    chk("fl_fwd_hit", 16'(fwd_hit), 16'd0);
    chk("fl_flags", 16'(flags), 16'h0008);

    // Flush discards a push into an empty stage
    drive(16'h0555, 4'b0000, PASS, 4'd3, 1'b1, 1'b0);
    flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("flpush_discard", 16'(out_valid), 16'd0);

    // Pop coinciding with flush still commits flags
    out_ready = 1'b1;
    drive(16'h0666, 4'b0010, ADD, 4'd3, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flpop_flags", 16'(flags), 16'h0002);
    chk("flpop_empty", 16'(out_valid), 16'd0);

    // Overflowed ADD
    out_ready = 1'b0;
    drive(16'h7fff, 4'b0001, ADD, 4'd5, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    fwd(4'd5);
`ifdef ALU_OVF_TRAP_EN
    chk("ovf_wr_en", 16'(out_wr_en), 16'd0);
    chk("ovf_fwd_hit", 16'(fwd_hit), 16'd0);
    chk("ovf_trap_idle", 16'(ovf_trap), 16'd0);
`else
    chk("ovf_wr_en", 16'(out_wr_en), 16'd1);
    chk("ovf_fwd_hit", 16'(fwd_hit), 16'd1);
    chk("ovf_fwd_data", fwd_data, 16'h7fff);
`endif
    out_ready = 1'b1;
    tick();
    chk("ovf_flags", 16'(flags), 16'h0001);
`ifdef ALU_OVF_TRAP_EN
    chk("ovf_trap_pulse", 16'(ovf_trap), 16'd1);
    tick();
    chk("ovf_trap_clear", 16'(ovf_trap), 16'd0);
`else
    tick();
`endif
    chk("ovf_empty", 16'(out_valid), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
